// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared fetch-path types and constants.
//            fetch_entry_t is the {pc, insn} pair carried from the fetch
//            queue to decode. Its PC field is fixed at XLEN_DEFAULT bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN         = 32;
  localparam int INSN_BYTES   = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN-1:0]         insn;
  } fetch_entry_t;

  // True for 1, 2, 4, 8, ...
  function automatic logic is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the fetch unit's instruction-memory port, redirect
//            input and decode-side valid/ready handshake.
// Modports : master - the fetch unit (drives imem_req/addr, fetch_* outputs)
//            slave  - the environment (memory, branch unit, decode)
// Signals  : imem_req, imem_addr, imem_rdata,
//            redirect_valid, redirect_pc,
//            fetch_valid, fetch_ready, fetch_pc, fetch_insn, misalign_err
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [ILEN-1:0] fetch_insn;

  logic            misalign_err;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_valid,
    input  fetch_ready,
    output fetch_pc,
    output fetch_insn,
    output misalign_err
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_pc,
    input  fetch_insn,
    input  misalign_err
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Purpose  : Small FIFO of fetch_entry_t between the memory response and
//            decode. Pointers carry an extra wrap bit so count = wr - rd
//            distinguishes full from empty.
// Ports    : clk, rst_n      - clock, async active-low reset
//            push / wdata    - write an entry (caller guarantees no overflow)
//            pop             - drop the head; ignored when empty
//            flush           - discard all entries; beats push and pop
//            head            - entry at the read pointer (valid if count!=0)
//            count           - number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [c_aw:0] r_wr_ptr;
  logic [c_aw:0] r_rd_ptr;
  logic          w_empty;
  logic          w_pop_en;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_pop_en = pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: nothing reads it until a push has landed.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
  end

  assign head  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign count = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Holds the fetch PC, issues word
//            reads to a 1-cycle synchronous instruction memory, queues the
//            returned {pc, insn} pairs and hands them to decode over a
//            valid/ready handshake. A redirect flushes everything in flight.
// Ports    : clk    - clock, all state on posedge
//            rst_n  - asynchronous active-low reset
//            bus    - fetch_unit_if.master (imem_*, redirect_*, fetch_*,
//                     misalign_err)
// Params   : XLEN (must equal XLEN_DEFAULT), RESET_VECTOR (4-byte aligned),
//            FETCH_Q_DEPTH (power of two, >= 2)
// Config   : FETCH_ALIGN_CHECK_EN - when defined, a misaligned redirect sets
//            misalign_err and blocks fetch until an aligned redirect; when
//            undefined the redirect PC is forced word-aligned and
//            misalign_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN          = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
  parameter int              FETCH_Q_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  fetch_unit_if.master bus
);

  localparam int              c_cnt_w  = $clog2(FETCH_Q_DEPTH) + 2;
  localparam logic [XLEN-1:0] c_step   = XLEN'(INSN_BYTES);
  localparam logic [XLEN-1:0] c_lo_msk = XLEN'(INSN_BYTES - 1);

  // Elaboration-time parameter checks.
  if (!is_pow2(FETCH_Q_DEPTH) || FETCH_Q_DEPTH < 2) begin : g_chk_depth
    $error("fetch_unit: FETCH_Q_DEPTH must be a power of two >= 2");
  end
  if ((RESET_VECTOR & c_lo_msk) != '0) begin : g_chk_vector
    $error("fetch_unit: RESET_VECTOR must be 4-byte aligned");
  end
  if (XLEN != XLEN_DEFAULT) begin : g_chk_xlen
    $error("fetch_unit: XLEN must match fetch_entry_t PC width");
  end

  logic [XLEN-1:0]                r_pc;
  logic                           r_inflight;
  logic [XLEN-1:0]                r_inflight_pc;

  logic [$clog2(FETCH_Q_DEPTH):0] w_count;
  logic [c_cnt_w-1:0]             w_occupancy;
  logic                           w_fetch_valid;
  logic                           w_pop;
  logic                           w_push;
  logic                           w_issue;
  logic                           w_misalign;
  logic [XLEN-1:0]                w_redirect_target;
  fetch_entry_t                   w_push_entry;
  fetch_entry_t                   w_head;

  // --------------------------------------------------------------------------
  // Redirect target / alignment handling
  // --------------------------------------------------------------------------
`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  // Misaligned targets are still loaded; fetch just stays parked on them
  // until an aligned redirect arrives.
  assign w_redirect_target = bus.redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_misalign <= ((bus.redirect_pc & c_lo_msk) != '0);
    end
  end

  assign w_misalign = r_misalign;
`else
  assign w_redirect_target = bus.redirect_pc & ~c_lo_msk;
  assign w_misalign        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Issue / push / pop decisions
  // --------------------------------------------------------------------------
  assign w_fetch_valid = (w_count != '0);
  assign w_pop         = w_fetch_valid & bus.fetch_ready;

  // Entries that will still occupy the queue after this cycle's pop,
  // counting the response already on its way. pop implies count >= 1,
  // so the subtraction never underflows.
  assign w_occupancy = c_cnt_w'(w_count) + c_cnt_w'(r_inflight) - c_cnt_w'(w_pop);

  // rst_n gates the request so imem_req reads 0 while reset is held.
  assign w_issue = rst_n & ~bus.redirect_valid & ~w_misalign &
                   (w_occupancy < c_cnt_w'(FETCH_Q_DEPTH));

  // A response landing in a redirect cycle belongs to the old stream.
  assign w_push = r_inflight & ~bus.redirect_valid;

  assign w_push_entry.pc   = r_inflight_pc;
  assign w_push_entry.insn = bus.imem_rdata;

  // --------------------------------------------------------------------------
  // PC and in-flight tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      r_pc       <= w_redirect_target;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + c_step;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  fetch_queue #(
    .DEPTH (FETCH_Q_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (bus.redirect_valid),
    .wdata (w_push_entry),
    .head  (w_head),
    .count (w_count)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.imem_req     = w_issue;
  assign bus.imem_addr    = r_pc;
  assign bus.fetch_valid  = w_fetch_valid;
  // Head data is masked while empty so stale storage never shows on the bus.
  assign bus.fetch_pc     = w_fetch_valid ? w_head.pc   : '0;
  assign bus.fetch_insn   = w_fetch_valid ? w_head.insn : '0;
  assign bus.misalign_err = w_misalign;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A reference model tracks the
//            requests issued since the last flush as a list of {issue cycle,
//            pc}; the head becomes visible two cycles after its request and
//            the request rule follows from the list length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN          (32),
    .RESET_VECTOR  (RV),
    .FETCH_Q_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous 1-cycle instruction memory: insn = addr ^ KEY.
  always @(posedge clk) bus.imem_rdata <= bus.imem_addr ^ KEY;

  // ---------------- reference model state ----------------
  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  int          cyc;
  logic [31:0] issue_pc;
  bit          mis;
  logic [98:0] exp_vec;
  bit          exp_pop;
  bit          exp_req;
  bit          cur_rv;
  logic [31:0] cur_rpc;
  logic [31:0] obs_pops[$];

  int total;
  int bad;

  function automatic logic [98:0] observe();
    return {bus.fetch_valid, bus.imem_req, bus.misalign_err,
            bus.fetch_valid ? bus.fetch_pc   : 32'h0,
            bus.fetch_valid ? bus.fetch_insn : 32'h0,
            bus.imem_req    ? bus.imem_addr  : 32'h0};
  endfunction

  task automatic model_reset();
    q.delete();
    cyc      = 0;
    issue_pc = RV;
    mis      = 1'b0;
  endtask

  // Drive one cycle's inputs, move to the falling edge, record what decode
  // accepted and compute the expected outputs for this cycle.
  task automatic cyc_begin(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit head_ok;
    int occ;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.fetch_ready    = rdy;
    cur_rv  = rv;
    cur_rpc = rpc;
    @(negedge clk);
    if (bus.fetch_valid === 1'b1 && rdy) obs_pops.push_back(bus.fetch_pc);
    head_ok = (q.size() > 0) && (q[0].cyc <= cyc - 2);
    exp_pop = head_ok && rdy;
    occ     = q.size() - (exp_pop ? 1 : 0);
    exp_req = !rv && !mis && (occ < DEPTH);
    exp_vec = {head_ok, exp_req, mis,
               head_ok ? q[0].pc : 32'h0,
               head_ok ? (q[0].pc ^ KEY) : 32'h0,
               exp_req ? issue_pc : 32'h0};
  endtask

  task automatic cyc_end();
    ent_t e;
    if (exp_pop) void'(q.pop_front());
    if (cur_rv) begin
      q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      issue_pc = cur_rpc;
      mis      = (cur_rpc[1:0] != 2'b00);
`else
      issue_pc = {cur_rpc[31:2], 2'b00};
`endif
    end else if (exp_req) begin
      e.cyc = cyc;
      e.pc  = issue_pc;
      q.push_back(e);
      issue_pc = issue_pc + 32'd4;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.fetch_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    obs_pops.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [98:0] got;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus.fetch_valid, bus.imem_req, bus.misalign_err, bus.fetch_pc, bus.fetch_insn, 32'h0};
    total++;
    if (got !== 99'h0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", got);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    obs_pops.delete();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b1);
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL stream cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
    total++;
    if (obs_pops.size() != 6 || obs_pops[0] !== RV) begin
      bad++;
      $display("FAIL stream_count pops=%0d want=6", obs_pops.size());
    end
  endtask

  task automatic test_backpressure();
    bit seq_ok;
    bit req_last_stall;
    for (int i = 0; i < 14; i++) begin
      cyc_begin(1'b0, 32'h0, (i >= 6));
      if (i == 5) req_last_stall = bus.imem_req;
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL backpressure cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
    total++;
    if (req_last_stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_req got=%b want=0", req_last_stall);
    end
    seq_ok = (obs_pops.size() == 14);
    for (int i = 0; i < obs_pops.size(); i++)
      if (obs_pops[i] !== RV + 32'(4 * i)) seq_ok = 1'b0;
    total++;
    if (!seq_ok) begin
      bad++;
      $display("FAIL pc_order pops=%0d want=14 contiguous from 0x100", obs_pops.size());
    end
  endtask

  task automatic test_redirect_full();
    logic        v_r1;
    logic        v_r3;
    logic [31:0] pc_r3;
    obs_pops.delete();
    for (int i = 0; i < 10; i++) begin
      cyc_begin(i == 0 || i == 3, (i == 0) ? 32'h200 : 32'h40, (i >= 4));
      if (i == 4) v_r1 = bus.fetch_valid;
      if (i == 6) begin v_r3 = bus.fetch_valid; pc_r3 = bus.fetch_pc; end
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL redirect_full cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
    total++;
    if (v_r1 !== 1'b0 || v_r3 !== 1'b1 || pc_r3 !== 32'h40) begin
      bad++;
      $display("FAIL redirect_timing v_r1=%b v_r3=%b pc_r3=%h want 0 1 00000040", v_r1, v_r3, pc_r3);
    end
    total++;
    if (obs_pops.size() != 4 || obs_pops[0] !== 32'h40) begin
      bad++;
      $display("FAIL redirect_stale pops=%0d first=%h want 4 00000040", obs_pops.size(),
               (obs_pops.size() > 0) ? obs_pops[0] : 32'h0);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc_begin(i == 4, 32'h300, 1'b1);
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL redirect_pop cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
    total++;
    if (obs_pops.size() != 5 || obs_pops[2] !== 32'h108 || obs_pops[3] !== 32'h300 ||
        obs_pops[4] !== 32'h304) begin
      bad++;
      $display("FAIL redirect_pop_seq pops=%0d want 100 104 108 300 304", obs_pops.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] got;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b0);
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      if (i < 3) cyc_end();
    end
    #1;
    rst_n = 1'b0;
    #1;
    got = {bus.fetch_valid, bus.imem_req, bus.misalign_err};
    total++;
    if (got !== 3'b000) begin
      bad++;
      $display("FAIL reset_async got=%b want=000", got);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    obs_pops.delete();
    for (int i = 0; i < 6; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b1);
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL reset_mid_post cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
    total++;
    if (obs_pops.size() != 4 || obs_pops[0] !== RV) begin
      bad++;
      $display("FAIL reset_mid_first pops=%0d want 4 starting 00000100", obs_pops.size());
    end
  endtask

  task automatic test_misalign();
    logic        chk_a;
    logic        chk_b;
    logic [31:0] chk_pc;
    for (int i = 0; i < 10; i++) begin
      cyc_begin(i == 0 || i == 5, (i == 0) ? 32'h42 : 32'h80, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
      if (i == 2) begin chk_a = bus.misalign_err; chk_b = bus.imem_req; end
      if (i == 8) chk_pc = bus.fetch_pc;
`else
      if (i == 3) begin chk_a = bus.misalign_err; chk_b = bus.fetch_valid; chk_pc = bus.fetch_pc; end
`endif
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL misalign cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
`ifdef FETCH_ALIGN_CHECK_EN
    total++;
    if (chk_a !== 1'b1 || chk_b !== 1'b0 || chk_pc !== 32'h80) begin
      bad++;
      $display("FAIL misalign_flag err=%b req=%b pc=%h want 1 0 00000080", chk_a, chk_b, chk_pc);
    end
`else
    total++;
    if (chk_a !== 1'b0 || chk_b !== 1'b1 || chk_pc !== 32'h40) begin
      bad++;
      $display("FAIL misalign_force err=%b valid=%b pc=%h want 0 1 00000040", chk_a, chk_b, chk_pc);
    end
`endif
  endtask

  task automatic test_random();
    bit          rv;
    bit          rdy;
    logic [31:0] rpc;
    for (int i = 0; i < 300; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      cyc_begin(rv, rpc, rdy);
      total++;
      if (observe() !== exp_vec) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, observe(), exp_vec);
      end
      cyc_end();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.fetch_ready    = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
